// File: rtl/key_filter_multi.sv
// key_filter_multi: KEY_NUM-channel debouncer for active-low push-buttons with long-press detection.
// Defining KEY_FILTER_REPEAT_EN builds the per-channel auto-repeat (key_rpt); otherwise key_rpt is tied low.
module key_filter_multi #(
  parameter int KEY_NUM      = 4,
  parameter int DEBOUNCE_CNT = 1000000,
  parameter int LONG_CNT     = 50000000,
  parameter int REPEAT_CNT   = 10000000,
  parameter int CNT_W        = 26
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_rpt
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    FILTER0 = 4'b0010,
    DOWN    = 4'b0100,
    FILTER1 = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CNT);
`ifdef KEY_FILTER_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CNT - 1);
`endif

  // Legal configuration envelope; the block is intentionally empty.
  if (KEY_NUM < 1 || KEY_NUM > 16 || DEBOUNCE_CNT < 2 || LONG_CNT < 2 || REPEAT_CNT < 1) begin : g_cfg_out_of_range
  end

  logic [KEY_NUM-1:0] sync1;
  logic [KEY_NUM-1:0] sync2;
  logic [KEY_NUM-1:0] edge_r;
  logic [KEY_NUM-1:0] nedge_r;
  logic [KEY_NUM-1:0] pedge_r;

  // Synchroniser and edge stage; edge strobes are registered before the FSMs see them.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1   <= {KEY_NUM{1'b1}};
      sync2   <= {KEY_NUM{1'b1}};
      edge_r  <= {KEY_NUM{1'b1}};
      nedge_r <= {KEY_NUM{1'b0}};
      pedge_r <= {KEY_NUM{1'b0}};
    end else begin
      sync1   <= key_in;
      sync2   <= sync1;
      edge_r  <= sync2;
      nedge_r <= edge_r & ~sync2;
      pedge_r <= ~edge_r & sync2;
    end
  end

  genvar g;
  generate
    for (g = 0; g < KEY_NUM; g++) begin : g_ch
      state_t           state_r;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_nxt;
      logic [CNT_W-1:0] hold_r;
      logic [CNT_W-1:0] hold_nxt;
      logic             flag_r;
      logic             flag_nxt;
      logic             level_r;
      logic             level_nxt;
      logic             long_r;
      logic             long_nxt;
`ifdef KEY_FILTER_REPEAT_EN
      logic [CNT_W-1:0] rcnt_r;
      logic [CNT_W-1:0] rcnt_nxt;
      logic             rpt_r;
      logic             rpt_nxt;
`endif

      // Next-state and next-output decode for one channel.
      always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        hold_nxt  = hold_r;
        flag_nxt  = 1'b0;
        level_nxt = level_r;
        long_nxt  = 1'b0;
`ifdef KEY_FILTER_REPEAT_EN
        rcnt_nxt  = rcnt_r;
        rpt_nxt   = 1'b0;
`endif
        case (state_r)
          IDLE: begin
            cnt_nxt  = CNT_ZERO;
            hold_nxt = CNT_ZERO;
`ifdef KEY_FILTER_REPEAT_EN
            rcnt_nxt = CNT_ZERO;
`endif
            if (nedge_r[g]) begin
              state_nxt = FILTER0;
            end else begin
              state_nxt = IDLE;
            end
          end
          FILTER0: begin
            if (pedge_r[g]) begin
              state_nxt = IDLE;
              cnt_nxt   = CNT_ZERO;
            end else if (cnt_r == DB_LAST) begin
              state_nxt = DOWN;
              cnt_nxt   = CNT_ZERO;
              hold_nxt  = CNT_ZERO;
              flag_nxt  = 1'b1;
              level_nxt = 1'b0;
`ifdef KEY_FILTER_REPEAT_EN
              rcnt_nxt  = CNT_ZERO;
`endif
            end else begin
              cnt_nxt = cnt_r + CNT_ONE;
            end
          end
          DOWN: begin
            // Hold count saturates at LONG_CNT, so LONG_LAST is crossed once per press.
            if (hold_r == LONG_LAST) begin
              long_nxt = 1'b1;
            end else begin
              long_nxt = 1'b0;
            end
            if (hold_r < LONG_MAX) begin
              hold_nxt = hold_r + CNT_ONE;
            end else begin
              hold_nxt = hold_r;
            end
`ifdef KEY_FILTER_REPEAT_EN
            if (hold_r == LONG_MAX) begin
              if (rcnt_r == RPT_LAST) begin
                rcnt_nxt = CNT_ZERO;
                rpt_nxt  = 1'b1;
              end else begin
                rcnt_nxt = rcnt_r + CNT_ONE;
              end
            end else begin
              rcnt_nxt = rcnt_r;
            end
`endif
            if (pedge_r[g]) begin
              state_nxt = FILTER1;
              cnt_nxt   = CNT_ZERO;
            end else begin
              state_nxt = DOWN;
            end
          end
          FILTER1: begin
            if (nedge_r[g]) begin
              state_nxt = DOWN;
              cnt_nxt   = CNT_ZERO;
            end else if (cnt_r == DB_LAST) begin
              state_nxt = IDLE;
              cnt_nxt   = CNT_ZERO;
              hold_nxt  = CNT_ZERO;
              flag_nxt  = 1'b1;
              level_nxt = 1'b1;
`ifdef KEY_FILTER_REPEAT_EN
              rcnt_nxt  = CNT_ZERO;
`endif
            end else begin
              cnt_nxt = cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_nxt = IDLE;
            cnt_nxt   = CNT_ZERO;
            hold_nxt  = CNT_ZERO;
            level_nxt = 1'b1;
`ifdef KEY_FILTER_REPEAT_EN
            rcnt_nxt  = CNT_ZERO;
`endif
          end
        endcase
      end

      // Channel state, counters and registered outputs.
      always_ff @(posedge Clk) begin
        if (Rst) begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          hold_r  <= CNT_ZERO;
          flag_r  <= 1'b0;
          level_r <= 1'b1;
          long_r  <= 1'b0;
`ifdef KEY_FILTER_REPEAT_EN
          rcnt_r  <= CNT_ZERO;
          rpt_r   <= 1'b0;
`endif
        end else begin
          state_r <= state_nxt;
          cnt_r   <= cnt_nxt;
          hold_r  <= hold_nxt;
          flag_r  <= flag_nxt;
          level_r <= level_nxt;
          long_r  <= long_nxt;
`ifdef KEY_FILTER_REPEAT_EN
          rcnt_r  <= rcnt_nxt;
          rpt_r   <= rpt_nxt;
`endif
        end
      end

      assign key_flag[g]  = flag_r;
      assign key_state[g] = level_r;
      assign key_long[g]  = long_r;
`ifdef KEY_FILTER_REPEAT_EN
      assign key_rpt[g]   = rpt_r;
`else
      assign key_rpt[g]   = 1'b0;
`endif
    end
  endgenerate

endmodule
